// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the datapath load/store port. Accepts one word
// request at a time over a valid/ready handshake, waits WAIT_CYCLES clocks,
// then serves the request from an internal word array and returns one or more
// response beats (read data, or a write acknowledge with zero data).
//
// Optional feature macro: DMEM_VBURST_EN
//   defined   - reads return req_len beats (0 -> 1, >5 -> 5) for vector loads
//   undefined - every read is a single beat; req_len is ignored
//
// Parameters
//   DEPTH        number of 32-bit words (power of two)
//   WAIT_CYCLES  wait states between accept and first beat (0..15)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  request present
//   req_ready  responder idle and able to accept (decoded from state only)
//   req_we     1 = write, 0 = read
//   req_addr   byte address (must be word aligned and inside DEPTH)
//   req_wdata  write data
//   req_len    read burst length in beats (burst build only)
//   rsp_valid  response beat valid (registered, no backpressure)
//   rsp_rdata  read data for this beat, 0 for acks and errors
//   rsp_last   final beat of the response
//   rsp_err    request rejected (misaligned or out of range)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_len,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_last,
    output logic        rsp_err
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT
    } state_t;

    state_t        state,    state_d;
    logic [3:0]    wait_cnt, wait_cnt_d;
    logic [AW-1:0] idx,      idx_d;
    logic          we_q,     we_d;
    logic          err_q,    err_d;
    logic [31:0]   wdata_q,  wdata_d;

    logic          rsp_valid_d;
    logic          rsp_last_d;
    logic          rsp_err_d;
    logic [31:0]   rsp_rdata_d;

    logic          accept;
    logic          addr_err;

    logic [31:0]   mem [DEPTH];

`ifdef DMEM_VBURST_EN
    logic [2:0]    beats, beats_d;

    // Vector loads are at most five words; a zero length still moves one.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len == 3'd0) return 3'd1;
        if (len > 3'd5)  return 3'd5;
        return len;
    endfunction
`else
    // Burst length has no meaning in the single-beat build.
    logic          unused_len;
    assign unused_len = ^req_len;
`endif

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;

    // Only the start address is checked; a burst that runs past the top of
    // the array simply wraps.
    assign addr_err  = (req_addr[1:0] != 2'b00) ||
                       ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves it unassigned and infers a latch.
        state_d    = state;
        wait_cnt_d = wait_cnt;
        idx_d      = idx;
        we_d       = we_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
`ifdef DMEM_VBURST_EN
        beats_d    = beats;
`endif

        case (state)
            S_IDLE: begin
                if (accept) begin
                    we_d       = req_we;
                    err_d      = addr_err;
                    idx_d      = req_addr[AW+1:2];
                    wdata_d    = req_wdata;
                    wait_cnt_d = WAIT_LOAD;
`ifdef DMEM_VBURST_EN
                    beats_d    = (req_we || addr_err) ? 3'd1 : clamp_len(req_len);
`endif
                    state_d    = (WAIT_LOAD != 4'd0) ? S_WAIT : S_BEAT;
                end
            end

            S_WAIT: begin
                wait_cnt_d = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) state_d = S_BEAT;
            end

            S_BEAT: begin
`ifdef DMEM_VBURST_EN
                if (!we_q && !err_q) begin
                    idx_d   = idx + AW'(1);
                    beats_d = beats - 3'd1;
                end
                if (beats == 3'd1) state_d = S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end

            default: state_d = S_IDLE;
        endcase

        // Response outputs are computed one cycle early from the next-state
        // values so that they can be registered without adding latency.
        rsp_valid_d = (state_d == S_BEAT);
        rsp_err_d   = rsp_valid_d & err_d;
`ifdef DMEM_VBURST_EN
        rsp_last_d  = rsp_valid_d & (beats_d == 3'd1);
`else
        rsp_last_d  = rsp_valid_d;
`endif
        rsp_rdata_d = (rsp_valid_d && !we_d && !err_d) ? mem[idx_d] : 32'h0;
    end

    // -------------------------------------------------------------------------
    // State and response registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            idx       <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= 32'h0;
`ifdef DMEM_VBURST_EN
            beats     <= 3'd0;
`endif
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            idx       <= idx_d;
            we_q      <= we_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
`ifdef DMEM_VBURST_EN
            beats     <= beats_d;
`endif
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_last  <= rsp_last_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Word array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; its contents are undefined until written,
    // and leaving it out of the reset keeps it mappable onto RAM.
    // A reset that lands before the BEAT edge forces IDLE, so an aborted write
    // never reaches the array.
    always_ff @(posedge clk) begin
        if (state == S_BEAT && we_q && !err_q) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the datapath's load/store port. It accepts word requests from the core through a valid/ready handshake, inserts a programmable number of wait states, and serves reads and writes from an internal word array. It returns read data, or a write acknowledge, on a response channel. It is the slave end of the interface driven by the datapath's `ALUResult`/`WriteData`/`ReadData` signals. It optionally supports multi-beat reads sized for vector register loads (1–5 words).

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; power of two.
- `WAIT_CYCLES`, 1: wait states inserted between request accept and first beat; range 0–15.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low (`reset`=0 resets).
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: write data.
- `req_len` input 3: read burst length in beats; only used with `DMEM_VBURST_EN`.
- `rsp_valid` output 1: response beat valid.
- `rsp_rdata` output 32: read data for the current beat.
- `rsp_last` output 1: final beat of the response.
- `rsp_err` output 1: request rejected (misaligned or out of range).

## Operation
State machine with states IDLE, WAIT and BEAT.

IDLE
- `req_ready`=1.
- A request is accepted when `req_valid & req_ready` is high on a clock edge.
- On accept, latch `we`, the word index `req_addr[31:2]`, `wdata` and the beat count.
- Next state is WAIT if `WAIT_CYCLES`>0, otherwise BEAT. The wait counter loads `WAIT_CYCLES`.

WAIT
- `req_ready`=0.
- The counter decrements every cycle.
- On the edge where the counter equals 1, go to BEAT.

BEAT
- `req_ready`=0, `rsp_valid`=1.
- The response channel has no backpressure; the core always samples `rsp_valid` beats.
- Read beat: `rsp_rdata` = `mem[idx]`. After the edge, `idx` = (`idx`+1) mod `DEPTH` and the beat count decrements.
- Write: single beat. `mem[idx]` is written on the BEAT edge; `rsp_rdata`=0 and `rsp_last`=1 (acknowledge).
- `rsp_last`=1 on the beat where remaining count equals 1. After the last beat, go to IDLE.

Error handling
- An error occurs when `req_addr[1:0]`≠0 or `req_addr[31:2]` ≥ `DEPTH`. The check uses the start address only.
- On error: a single beat with `rsp_err`=1, `rsp_last`=1 and `rsp_rdata`=0. No memory write. Burst length is ignored.

Burst addressing
- The index wraps modulo `DEPTH` inside a burst with no error.

Memory contents
- Not cleared by reset. Contents are undefined until written.

## Timing
- Reset (async assert): state=IDLE, counter=0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_last`=0, `rsp_err`=0.
- Reset mid-operation aborts the transfer immediately. A write whose BEAT edge has not occurred is not performed.
- Latency: a request accepted at edge N gives its first beat valid during cycle N+1+`WAIT_CYCLES`. Burst beats follow on consecutive cycles.
- Occupancy: the block accepts a new request in the cycle after the last beat. Occupancy is 1+`WAIT_CYCLES`+beats cycles. There is no overlap of consecutive requests.
- `rsp_*` outputs are registered. `req_ready` is decoded from state only, with no combinational path from `req_valid`.
- Read-during-write cannot occur: only one transfer is active at a time.

## Configuration
`DMEM_VBURST_EN`:
- Defined: reads use `req_len` as the beat count. A value of 0 is treated as 1, and values above 5 are clamped to 5, matching five vector words. Writes remain single-beat.
- Undefined: `req_len` is ignored, every read is one beat, and the beat counter logic is absent.

## Test plan
- Reset release with `WAIT_CYCLES`=1: write 0xDEADBEEF to 0x10, then read 0x10. Required: write ack (`rsp_valid`=1, `rsp_last`=1) in cycle N+2; read returns 0xDEADBEEF two cycles after its accept.
- `WAIT_CYCLES`=0, back-to-back reads of 0x0 and 0x4 with `req_valid` held high. Required: `req_ready` low for exactly one cycle per request; data appears one cycle after each accept.
- `DMEM_VBURST_EN`, `DEPTH`=64: preload words 62, 63, 0, 1 with 0xA0–0xA3, then read at 0xF8 with `req_len`=4. Required: four consecutive beats 0xA0, 0xA1, 0xA2, 0xA3, with `rsp_last` only on the fourth (wrap).
- `DMEM_VBURST_EN`, read with `req_len`=7. Required: five beats. `req_len`=0 gives one beat.
- Write to 0x13 (misaligned), and read of 0x100 with `DEPTH`=64. Required: one beat each with `rsp_err`=1 and `rsp_rdata`=0; word 4 is unchanged.
- Assert `reset`=0 during WAIT of a write to 0x20, then read 0x20 after release. Required: outputs go to 0 immediately, `req_ready`=1, and the old value is returned.
